// File: rtl/mux2_4b_rr_arbiter_pkg.sv
// rtl/mux2_4b_rr_arbiter_pkg.sv - shared buffer state encoding and message width
package mux2_4b_rr_arbiter_pkg;

  localparam int MSG_W = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/mux2_4b_rr_arbiter_mux.sv
// rtl/mux2_4b_rr_arbiter_mux.sv - gate-level 2:1 data select, sel=1 picks in1
module Mux2_4b_struct
  import mux2_4b_rr_arbiter_pkg::*;
(
  input  logic [MSG_W-1:0] in0,
  input  logic [MSG_W-1:0] in1,
  input  logic             sel,
  output logic [MSG_W-1:0] out
);

  logic sel_n;

  assign sel_n = ~sel;

  for (genvar i = 0; i < MSG_W; i++) begin : g_bit
    assign out[i] = (in0[i] & sel_n) | (in1[i] & sel);
  end

endmodule

// File: rtl/mux2_4b_rr_arbiter.sv
// rtl/mux2_4b_rr_arbiter.sv - two-requester round-robin arbiter with a one-entry output buffer
module mux2_4b_rr_arbiter
  import mux2_4b_rr_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in0_val,
  output logic             in0_rdy,
  input  logic [MSG_W-1:0] in0_msg,
  input  logic             in1_val,
  output logic             in1_rdy,
  input  logic [MSG_W-1:0] in1_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [MSG_W-1:0] out_msg,
  output logic             out_src
);

  buf_state_e       state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             src_q, src_d;
  logic             prio_q, prio_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             grant_idx;
  logic             accept;
  logic [MSG_W-1:0] sel_msg;

  Mux2_4b_struct u_mux (
    .in0 (in0_msg),
    .in1 (in1_msg),
    .sel (grant_idx),
    .out (sel_msg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      msg_q   <= '0;
      src_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      src_q   <= src_d;
      prio_q  <= prio_d;
    end
  end

  // A drain without a refill keeps msg/src so the last value stays visible.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    src_d   = src_q;
    prio_d  = prio_q;
    if (accept) begin
      state_d = ST_FULL;
      msg_d   = sel_msg;
      src_d   = grant_idx;
      prio_d  = ~grant_idx;
    end else if (state_q == ST_FULL && out_rdy) begin
      state_d = ST_EMPTY;
    end
  end

  // rdy depends only on state, out_rdy, the vals and reset, never on out_msg.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || out_rdy;
    grant0     = in0_val && (!in1_val || !prio_q);
    grant1     = in1_val && (!in0_val || prio_q);
    grant_idx  = grant1;
    in0_rdy    = !reset && can_accept && grant0;
    in1_rdy    = !reset && can_accept && grant1;
    accept     = in0_rdy || in1_rdy;
    out_val    = (state_q == ST_FULL);
    out_msg    = msg_q;
    out_src    = src_q;
  end

endmodule

// File: tb/tb_mux2_4b_rr_arbiter.sv
// tb/tb_mux2_4b_rr_arbiter.sv - directed vector table plus randomized scoreboard run
module tb_mux2_4b_rr_arbiter;
  import mux2_4b_rr_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             in0_val, in1_val, out_rdy;
  logic [MSG_W-1:0] in0_msg, in1_msg;
  logic             in0_rdy, in1_rdy, out_val, out_src;
  logic [MSG_W-1:0] out_msg;

  always #5 clk = ~clk;

  mux2_4b_rr_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .in0_val (in0_val),
    .in0_rdy (in0_rdy),
    .in0_msg (in0_msg),
    .in1_val (in1_val),
    .in1_rdy (in1_rdy),
    .in1_msg (in1_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  typedef struct {
    logic             rst;
    logic             v0;
    logic [MSG_W-1:0] m0;
    logic             v1;
    logic [MSG_W-1:0] m1;
    logic             ordy;
    logic             e_r0;
    logic             e_r1;
    logic             e_val;
    logic [MSG_W-1:0] e_msg;
    logic             e_src;
  } vec_t;

  typedef struct {
    logic             src;
    logic [MSG_W-1:0] msg;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];

  int checks = 0;
  int errors = 0;

  buf_state_e m_state;
  logic       m_prio;
  bit         took0, took1;
  int         seq0, seq1, del0, del1, lose0, lose1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic v0, input logic [MSG_W-1:0] m0,
                     input logic v1, input logic [MSG_W-1:0] m1, input logic ordy,
                     input logic e_r0, input logic e_r1, input logic e_val,
                     input logic [MSG_W-1:0] e_msg, input logic e_src);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.m0 = m0; v.v1 = v1; v.m1 = m1; v.ordy = ordy;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_val = e_val; v.e_msg = e_msg; v.e_src = e_src;
    vecs.push_back(v);
  endtask

  // One random (or drain-only) cycle checked against an independent model.
  task automatic step(input bit rnd);
    ent_t e;
    bit   ca, g0, g1, a0, a1, drain;
    @(posedge clk);
    #1;
    reset = 1'b0;
    if (rnd) begin
      if (!in0_val || took0) begin
        in0_val = ($urandom_range(0, 9) < 6);
        in0_msg = seq0[MSG_W-1:0];
      end
      if (!in1_val || took1) begin
        in1_val = ($urandom_range(0, 9) < 6);
        in1_msg = seq1[MSG_W-1:0] ^ 4'hF;
      end
      out_rdy = ($urandom_range(0, 9) < 7);
    end else begin
      in0_val = 1'b0;
      in1_val = 1'b0;
      out_rdy = 1'b1;
    end
    @(negedge clk);
    ca = (m_state == ST_EMPTY) || out_rdy;
    g0 = in0_val && (!in1_val || !m_prio);
    g1 = in1_val && (!in0_val || m_prio);
    a0 = ca && g0;
    a1 = ca && g1;
    chk("rnd_in0_rdy", int'(in0_rdy), int'(a0));
    chk("rnd_in1_rdy", int'(in1_rdy), int'(a1));
    chk("rnd_out_val", int'(out_val), int'(m_state == ST_FULL));
    drain = (m_state == ST_FULL) && out_rdy;
    if (drain && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rnd_out_msg", int'(out_msg), int'(e.msg));
      chk("rnd_out_src", int'(out_src), int'(e.src));
      if (e.src) del1++;
      else del0++;
    end
    took0 = a0;
    took1 = a1;
    if (a0) begin
      e.src = 1'b0; e.msg = in0_msg;
      sb.push_back(e);
      seq0++;
      m_prio = 1'b1;
      lose0 = 0;
      if (in1_val) lose1++;
    end
    if (a1) begin
      e.src = 1'b1; e.msg = in1_msg;
      sb.push_back(e);
      seq1++;
      m_prio = 1'b0;
      lose1 = 0;
      if (in0_val) lose0++;
    end
    if (a0 || a1) begin
      chk("starve0", int'(lose0 > 1), 0);
      chk("starve1", int'(lose1 > 1), 0);
    end
    if (a0 || a1) m_state = ST_FULL;
    else if (drain) m_state = ST_EMPTY;
  endtask

  initial begin
    //   rst v0 m0    v1 m1    ordy | r0 r1 val msg   src
    add(1, 1, 4'hA, 1, 4'hC, 1,   0, 0, 0, 4'h0, 0);
    add(0, 1, 4'hA, 0, 4'h0, 1,   1, 0, 1, 4'hA, 0);
    add(0, 0, 4'h0, 0, 4'h0, 1,   0, 0, 0, 4'hA, 0);
    add(1, 1, 4'h3, 1, 4'hC, 1,   0, 0, 0, 4'h0, 0);
    add(0, 1, 4'h3, 1, 4'hC, 1,   1, 0, 1, 4'h3, 0);
    add(0, 1, 4'h3, 1, 4'hC, 1,   0, 1, 1, 4'hC, 1);
    add(0, 1, 4'h3, 1, 4'hC, 1,   1, 0, 1, 4'h3, 0);
    add(0, 1, 4'h3, 1, 4'hC, 1,   0, 1, 1, 4'hC, 1);
    add(0, 1, 4'h5, 0, 4'h0, 1,   1, 0, 1, 4'h5, 0);
    add(0, 1, 4'h3, 1, 4'hC, 0,   0, 0, 1, 4'h5, 0);
    add(0, 1, 4'h3, 1, 4'hC, 0,   0, 0, 1, 4'h5, 0);
    add(0, 1, 4'h3, 1, 4'hC, 1,   0, 1, 1, 4'hC, 1);
    add(1, 0, 4'h0, 1, 4'hE, 0,   0, 0, 0, 4'h0, 0);
    add(0, 0, 4'h0, 1, 4'h1, 1,   0, 1, 1, 4'h1, 1);
    add(0, 0, 4'h0, 1, 4'h2, 1,   0, 1, 1, 4'h2, 1);
    add(0, 0, 4'h0, 1, 4'h4, 1,   0, 1, 1, 4'h4, 1);
    add(0, 1, 4'h6, 1, 4'h7, 1,   1, 0, 1, 4'h6, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0,   0, 0, 1, 4'h6, 0);
    add(0, 0, 4'h0, 0, 4'h0, 1,   0, 0, 0, 4'h6, 0);
    add(0, 1, 4'h8, 1, 4'h9, 1,   0, 1, 1, 4'h9, 1);
    add(0, 1, 4'h8, 0, 4'h0, 0,   0, 0, 1, 4'h9, 1);

    reset = 1'b1; in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
    in0_msg = '0; in1_msg = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      in0_val = vecs[i].v0;
      in0_msg = vecs[i].m0;
      in1_val = vecs[i].v1;
      in1_msg = vecs[i].m1;
      out_rdy = vecs[i].ordy;
      #3;
      chk($sformatf("v%0d_in0_rdy", i), int'(in0_rdy), int'(vecs[i].e_r0));
      chk($sformatf("v%0d_in1_rdy", i), int'(in1_rdy), int'(vecs[i].e_r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_val", i), int'(out_val), int'(vecs[i].e_val));
      chk($sformatf("v%0d_out_msg", i), int'(out_msg), int'(vecs[i].e_msg));
      chk($sformatf("v%0d_out_src", i), int'(out_src), int'(vecs[i].e_src));
    end

    reset = 1'b1; in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
    m_state = ST_EMPTY; m_prio = 1'b0; took0 = 1'b0; took1 = 1'b0;
    seq0 = 0; seq1 = 0; del0 = 0; del1 = 0; lose0 = 0; lose1 = 0;
    @(posedge clk);
    for (int c = 0; c < 1000; c++) step(1'b1);
    for (int c = 0; c < 4; c++) step(1'b0);
    chk("sb_empty", sb.size(), 0);
    chk("lossless_src0", del0, seq0);
    chk("lossless_src1", del1, seq1);
    chk("src0_served", int'(del0 > 50), 1);
    chk("src1_served", int'(del1 > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
